// File: rtl/admo_id_ex_pkg.sv
// admo_id_ex_pkg: shared widths and operand-select encodings for the ID/EX stage.
//   DATA_WIDTH     default operand/PC width
//   a_sel_e        ALU A source select (rs1 / pc / zero)
//   b_sel_e        ALU B source select (rs2 / imm)
package admo_id_ex_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        A_SEL_RS1  = 2'b00,
        A_SEL_PC   = 2'b01,
        A_SEL_ZERO = 2'b10
    } a_sel_e;

    typedef enum logic {
        B_SEL_RS2 = 1'b0,
        B_SEL_IMM = 1'b1
    } b_sel_e;

endpackage

// File: rtl/admo_id_ex_if.sv
// admo_id_ex_if: decode-side handshake, forwarding sources and execute-side outputs of the ID/EX stage.
//   master  drives the decoded instruction, forward sources, flush and ex_ready
//   slave   the stage itself: drives id_ready, the registered ALU operands and side-band
interface admo_id_ex_if #(
    parameter int DATA_WIDTH = admo_id_ex_pkg::DATA_WIDTH,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic                  id_ready;
    logic [DATA_WIDTH-1:0] id_pc;
    logic [DATA_WIDTH-1:0] id_rs1_data;
    logic [DATA_WIDTH-1:0] id_rs2_data;
    logic [DATA_WIDTH-1:0] id_imm;
    logic [REG_AW-1:0]     id_rs1_addr;
    logic [REG_AW-1:0]     id_rs2_addr;
    logic [REG_AW-1:0]     id_rd_addr;
    logic [1:0]            id_a_sel;
    logic                  id_b_sel;
    logic [3:0]            id_alu_op;
    logic                  id_rd_we;
    logic                  mem_rd_we;
    logic [REG_AW-1:0]     mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  wb_rd_we;
    logic [REG_AW-1:0]     wb_rd_addr;
    logic [DATA_WIDTH-1:0] wb_rd_data;
    logic                  flush;
    logic                  ex_valid;
    logic                  ex_ready;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [3:0]            alu_op;
    logic [DATA_WIDTH-1:0] ex_rs2_data;
    logic [REG_AW-1:0]     ex_rd_addr;
    logic                  ex_rd_we;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_a_sel, id_b_sel,
               id_alu_op, id_rd_we, mem_rd_we, mem_rd_addr, mem_rd_data,
               wb_rd_we, wb_rd_addr, wb_rd_data, flush, ex_ready,
        input  id_ready, ex_valid, alu_a, alu_b, alu_op, ex_rs2_data,
               ex_rd_addr, ex_rd_we, stall_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_a_sel, id_b_sel,
               id_alu_op, id_rd_we, mem_rd_we, mem_rd_addr, mem_rd_data,
               wb_rd_we, wb_rd_addr, wb_rd_data, flush, ex_ready,
        output id_ready, ex_valid, alu_a, alu_b, alu_op, ex_rs2_data,
               ex_rd_addr, ex_rd_we, stall_cnt
    );

endinterface

// File: rtl/admo_fwd_mux.sv
// admo_fwd_mux: combinational operand forwarding for one source register.
//   addr_i                      source register index
//   rf_data_i                   register-file value from decode
//   mem_we_i/addr_i/data_i      MEM-stage writeback (highest priority)
//   wb_we_i/addr_i/data_i       WB-stage writeback
//   data_o                      forwarded operand
module admo_fwd_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5
) (
    input  logic [REG_AW-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0] rf_data_i,
    input  logic                  mem_we_i,
    input  logic [REG_AW-1:0]     mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  wb_we_i,
    input  logic [REG_AW-1:0]     wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic [DATA_WIDTH-1:0] data_o
);
    logic nz;
    logic mem_hit;
    logic wb_hit;

    // x0 is hardwired, so a pending write to it must never be forwarded
    assign nz      = |addr_i;
    assign mem_hit = nz && mem_we_i && (mem_addr_i == addr_i);
    assign wb_hit  = nz && wb_we_i && (wb_addr_i == addr_i);
    assign data_o  = mem_hit ? mem_data_i : wb_hit ? wb_data_i : rf_data_i;

endmodule

// File: rtl/admo_id_ex.sv
// admo_id_ex: decode-to-execute pipeline register with MEM/WB operand forwarding.
//   clk, rst   clock and synchronous active-high reset
//   bus_if     slave side of admo_id_ex_if: ID handshake and fields in, forward
//              sources and flush in, registered ALU operands/opcode, store data,
//              destination, ex_valid handshake and saturating stall counter out
module admo_id_ex #(
    parameter int DATA_WIDTH = admo_id_ex_pkg::DATA_WIDTH,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 16
) (
    input logic          clk,
    input logic          rst,
    admo_id_ex_if.slave  bus_if
);
    import admo_id_ex_pkg::*;

    logic [DATA_WIDTH-1:0] rs1_fwd;
    logic [DATA_WIDTH-1:0] rs2_fwd;
    logic [DATA_WIDTH-1:0] a_d;
    logic [DATA_WIDTH-1:0] b_d;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] rs2_q;
    logic [3:0]            op_q;
    logic [REG_AW-1:0]     rd_q;
    logic                  rd_we_d;
    logic                  rd_we_q;
    logic                  valid_d;
    logic                  valid_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  ready;
    logic                  xfer;
    logic                  stall;

    admo_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_AW(REG_AW)) u_fwd_rs1 (
        .addr_i     (bus_if.id_rs1_addr),
        .rf_data_i  (bus_if.id_rs1_data),
        .mem_we_i   (bus_if.mem_rd_we),
        .mem_addr_i (bus_if.mem_rd_addr),
        .mem_data_i (bus_if.mem_rd_data),
        .wb_we_i    (bus_if.wb_rd_we),
        .wb_addr_i  (bus_if.wb_rd_addr),
        .wb_data_i  (bus_if.wb_rd_data),
        .data_o     (rs1_fwd)
    );

    admo_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_AW(REG_AW)) u_fwd_rs2 (
        .addr_i     (bus_if.id_rs2_addr),
        .rf_data_i  (bus_if.id_rs2_data),
        .mem_we_i   (bus_if.mem_rd_we),
        .mem_addr_i (bus_if.mem_rd_addr),
        .mem_data_i (bus_if.mem_rd_data),
        .wb_we_i    (bus_if.wb_rd_we),
        .wb_addr_i  (bus_if.wb_rd_addr),
        .wb_data_i  (bus_if.wb_rd_data),
        .data_o     (rs2_fwd)
    );

    always_comb begin
        // flush forces ready so the upstream drains while the incoming word is dropped
        ready   = !valid_q || bus_if.ex_ready || bus_if.flush;
        xfer    = bus_if.id_valid && ready && !bus_if.flush;
        stall   = bus_if.id_valid && !ready && !bus_if.flush;
        a_d     = (bus_if.id_a_sel == A_SEL_RS1) ? rs1_fwd :
                  (bus_if.id_a_sel == A_SEL_PC)  ? bus_if.id_pc : '0;
        b_d     = (bus_if.id_b_sel == B_SEL_IMM) ? bus_if.id_imm : rs2_fwd;
        valid_d = bus_if.flush ? 1'b0 : xfer ? 1'b1 : bus_if.ex_ready ? 1'b0 : valid_q;
        rd_we_d = bus_if.flush ? 1'b0 : xfer ? bus_if.id_rd_we : rd_we_q;
        cnt_d   = (stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            rd_we_q <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rs2_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            rd_we_q <= rd_we_d;
            cnt_q   <= cnt_d;
            if (xfer) begin
                a_q   <= a_d;
                b_q   <= b_d;
                rs2_q <= rs2_fwd;
                op_q  <= bus_if.id_alu_op;
                rd_q  <= bus_if.id_rd_addr;
            end
        end
    end

    assign bus_if.id_ready    = ready;
    assign bus_if.ex_valid    = valid_q;
    assign bus_if.alu_a       = a_q;
    assign bus_if.alu_b       = b_q;
    assign bus_if.alu_op      = op_q;
    assign bus_if.ex_rs2_data = rs2_q;
    assign bus_if.ex_rd_addr  = rd_q;
    assign bus_if.ex_rd_we    = rd_we_q;
    assign bus_if.stall_cnt   = cnt_q;

endmodule
